// File: rtl/sftm_pkg.sv
// Shared types and helpers for the SFTM schedulers.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   state_t         scheduler FSM state encoding (S_IDLE..S_ERR)
//   GROUP_ROWS_DEF  default rows per sftm group
//   ceil_div()      integer ceiling division
package sftm_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam int GROUP_ROWS_DEF = 4;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 32'd1) / d;
  endfunction

endpackage

// File: rtl/sftm_credit_ctr.sv
// Saturating credit pool: starts full, one credit taken per dec, one returned per inc.
// Latency: count/nonzero reflect inc/dec one cycle after they are sampled.
// Backpressure: none; returns beyond CREDITS are dropped, dec on an empty pool is ignored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pool refilled to CREDITS)
//   inc          credit returned this cycle
//   dec          credit consumed this cycle
//   count        current credit count
//   nonzero      count != 0
module sftm_credit_ctr #(
  parameter int CREDITS = 2,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          nonzero
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FULL;
    end else begin
      // inc and dec together cancel out, so only the single-sided cases move the count.
      case ({inc, dec})
        2'b10: if (count != FULL) count <= count + CW'(1);
        2'b01: if (count != '0)   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/sftm_group_sched.sv
// Frame scheduler: splits a frame into GROUP_ROWS-row groups and issues one sftm start per group.
// Latency: frame_start -> sftm_start 2 cycles; group_done -> next sftm_start 2 cycles;
//   last group_done -> frame_done 2 cycles (also frame_start -> frame_done for an empty frame).
// Backpressure: each start consumes a downstream credit; with none left the FSM parks in ISSUE.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   frame_start            1-cycle pulse, accepted only in IDLE (latches frame_rows/bypass_cfg)
//   frame_rows, bypass_cfg frame geometry and bypass mode
//   abort                  synchronous abort, overrides everything
//   credit_return          downstream freed one group buffer
//   sftm_group_done        sftm finished the current group
//   sftm_group_data_valid  one row beat from sftm
//   sftm_start             1-cycle start pulse to sftm (coincides with first WAIT cycle)
//   sftm_bypass            latched bypass while busy, 0 in IDLE
//   group_idx              index of the group in flight
//   busy                   FSM not in IDLE
//   frame_done             1-cycle pulse once the frame completes
//   err_timeout            high while in ERR
//   err_beats              sticky short/long-group flag, cleared by the next accepted frame
module sftm_group_sched
  import sftm_pkg::*;
#(
  parameter int GROUP_ROWS = GROUP_ROWS_DEF,
  parameter int ROWS_W     = 12,
  parameter int GRP_W      = 10,
  parameter int CREDITS    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [ROWS_W-1:0] frame_rows,
  input  logic              bypass_cfg,
  input  logic              abort,
  input  logic              credit_return,
  input  logic              sftm_group_done,
  input  logic              sftm_group_data_valid,
  output logic              sftm_start,
  output logic              sftm_bypass,
  output logic [GRP_W-1:0]  group_idx,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              err_beats
);

  localparam int CW     = $clog2(CREDITS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int BEAT_W = $clog2(GROUP_ROWS + 2);

  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX  = {BEAT_W{1'b1}};
  localparam logic [BEAT_W-1:0] BEAT_GOOD = BEAT_W'(GROUP_ROWS);

  state_t             state;
  logic [GRP_W-1:0]   ngroups;
  logic [GRP_W-1:0]   ngroups_calc;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_next;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CW-1:0]      credit_cnt;
  logic               credit_nz;
  logic               credit_avail;
  logic               issue_fire;
  logic               last_grp;

  assign ngroups_calc = GRP_W'(ceil_div(32'(frame_rows), $unsigned(GROUP_ROWS)));

  // A credit returned in the same cycle is usable at once, so a starved ISSUE
  // restarts one cycle after the return instead of two.
  assign credit_avail = credit_nz | credit_return;
  assign issue_fire   = (state == S_ISSUE) && !abort && credit_avail;
  assign last_grp     = (group_idx == ngroups - GRP_W'(1));
  assign busy         = (state != S_IDLE);

  // Beat count including a beat arriving alongside group_done; saturates so a
  // runaway sftm cannot wrap back to a "good" count.
  always_comb begin
    beat_next = beat_cnt;
    if (sftm_group_data_valid && (beat_cnt != BEAT_MAX)) begin
      beat_next = beat_cnt + BEAT_W'(1);
    end
  end

  sftm_credit_ctr #(
    .CREDITS (CREDITS),
    .CW      (CW)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (credit_return),
    .dec     (issue_fire),
    .count   (credit_cnt),
    .nonzero (credit_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ngroups     <= '0;
      group_idx   <= '0;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
      sftm_start  <= 1'b0;
      sftm_bypass <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      err_beats   <= 1'b0;
    end else begin
      sftm_start <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        group_idx   <= '0;
        err_timeout <= 1'b0;
        sftm_bypass <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (frame_start) begin
              ngroups     <= ngroups_calc;
              sftm_bypass <= bypass_cfg;
              err_beats   <= 1'b0;
              group_idx   <= '0;
              state       <= (frame_rows == '0) ? S_DONE : S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (issue_fire) begin
              sftm_start <= 1'b1;
              beat_cnt   <= '0;
              tmo_cnt    <= '0;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            tmo_cnt  <= tmo_cnt + TMO_W'(1);
            beat_cnt <= beat_next;
            // group_done takes precedence over a timeout in the same cycle.
            if (sftm_group_done) begin
              if (beat_next != BEAT_GOOD) err_beats <= 1'b1;
              group_idx <= group_idx + GRP_W'(1);
              state     <= last_grp ? S_DONE : S_ISSUE;
            end else if (tmo_cnt == TMO_LAST) begin
              // Raised on entry so it lines up with the ERR state itself.
              err_timeout <= 1'b1;
              state       <= S_ERR;
            end
          end
          S_DONE: begin
            frame_done  <= 1'b1;
            group_idx   <= '0;
            sftm_bypass <= 1'b0;
            state       <= S_IDLE;
          end
          S_ERR: begin
            // Parked until abort; late group_done is deliberately ignored.
            state <= S_ERR;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Credit count can never exceed the pool size.
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) credit_cnt <= CW'(CREDITS));

endmodule
